// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the shared external data memory port.
// Latches the granted request, issues it for one cycle, then waits for ready with a timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_done_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_done_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        sel_m1;
  logic        gnt;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  // On a tie the requester that did not own the port last time wins.
  assign sel_m1 = m1_req_i & (~m0_req_i | ~last_owner_q);

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    gnt          = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    rdata        = '0;
    mem_req_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          gnt          = 1'b1;
          owner_d      = sel_m1;
          last_owner_d = sel_m1;
          we_d         = sel_m1 ? m1_we_i    : m0_we_i;
          be_d         = sel_m1 ? m1_be_i    : m0_be_i;
          addr_d       = sel_m1 ? m1_addr_i  : m0_addr_i;
          wdata_d      = sel_m1 ? m1_wdata_i : m0_wdata_i;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_o = 1'b1;
        cnt_d     = '0;
        state_d   = RESP;
      end
      RESP: begin
        if (mem_ready_i) begin
          done    = 1'b1;
          rdata   = mem_rdata_i;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done    = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // Grant is combinational from req, so it must be masked while reset is held.
  assign m0_gnt_o    = rst_ni & gnt & ~sel_m1;
  assign m1_gnt_o    = rst_ni & gnt &  sel_m1;

  assign m0_done_o   = done & ~owner_q;
  assign m1_done_o   = done &  owner_q;
  assign m0_err_o    = err  & ~owner_q;
  assign m1_err_o    = err  &  owner_q;
  assign m0_rdata_o  = owner_q ? '0 : rdata;
  assign m1_rdata_o  = owner_q ? rdata : '0;

  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares on every issue and completion.
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic        m0_gnt_o, m0_done_o, m0_err_o, m1_gnt_o, m1_done_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ready_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_gnt_o(m0_gnt_o), .m0_done_o(m0_done_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_gnt_o(m1_gnt_o), .m1_done_o(m1_done_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_note(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } done_t;

  issue_t exp_issue[$];
  done_t  exp_done[$];
  issue_t ei;
  done_t  ed;
  int     gnt_cyc = 0;
  int     gnt_log[$];

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (m0_gnt_o || m1_gnt_o) begin
        check("gnt_onehot", {31'b0, m0_gnt_o & m1_gnt_o}, 32'd0);
        gnt_cyc = cyc;
        gnt_log.push_back(cyc);
      end
      if (mem_req_o) begin
        if (exp_issue.size() == 0) begin
          check("unexpected_issue", {31'b0, mem_req_o}, 32'd0);
        end else begin
          ei = exp_issue.pop_front();
          check("issue_latency", cyc - gnt_cyc, 32'd1);
          check("issue_we",    {31'b0, mem_we_o}, {31'b0, ei.we});
          check("issue_be",    {28'b0, mem_be_o}, {28'b0, ei.be});
          check("issue_addr",  mem_addr_o,  ei.addr);
          check("issue_wdata", mem_wdata_o, ei.wdata);
        end
      end
      if (m0_done_o || m1_done_o) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", {30'b0, m1_done_o, m0_done_o}, 32'd0);
        end else begin
          ed = exp_done.pop_front();
          check("done_owner", {30'b0, m1_done_o, m0_done_o}, ed.owner ? 32'd2 : 32'd1);
          check("done_err",   {31'b0, ed.owner ? m1_err_o : m0_err_o}, {31'b0, ed.err});
          check("done_rdata", ed.owner ? m1_rdata_o : m0_rdata_o, ed.rdata);
          check("done_latency", cyc - gnt_cyc, ed.lat);
          check("nonowner_rdata", ed.owner ? m0_rdata_o : m1_rdata_o, 32'd0);
          check("nonowner_err", {31'b0, ed.owner ? m0_err_o : m1_err_o}, 32'd0);
        end
      end
    end
  end

  // Memory model: ready after mem_delay RESP cycles; rdata is the pre-write word.
  logic [31:0] mem [16];
  int          mem_delay = 0;
  int          wait_left = 0;
  bit          pend = 0;

  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk_i);
      #1;
      mem_ready_i = 1'b0;
      mem_rdata_i = 32'hDEAD_BEEF;
      if (rst_ni !== 1'b1) begin
        pend = 0;
      end else if (mem_req_o) begin
        pend      = 1;
        wait_left = mem_delay;
      end else if (pend) begin
        if (wait_left == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem[mem_addr_o[5:2]];
          if (mem_we_o)
            for (int b = 0; b < 4; b++)
              if (mem_be_o[b]) mem[mem_addr_o[5:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
          pend = 0;
        end else begin
          wait_left--;
        end
      end
    end
  end

  task automatic expect_xfer(input logic owner, input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic err, input int lat);
    exp_issue.push_back('{we: we, be: be, addr: addr, wdata: wdata});
    exp_done.push_back('{owner: owner, err: err, rdata: rdata, lat: lat});
  endtask

  // Called between edges; holds req until gnt, then drops it after the latching edge.
  task automatic do_req(input logic owner, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bit got = 0;
    if (!owner) begin
      m0_req_i = 1'b1; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wdata_i = wdata;
    end else begin
      m1_req_i = 1'b1; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wdata_i = wdata;
    end
    #1;
    for (int i = 0; i < 100; i++) begin
      if ((owner ? m1_gnt_o : m0_gnt_o) === 1'b1) begin
        got = 1;
        break;
      end
      @(posedge clk_i);
      #2;
    end
    if (!got) fail_note("gnt_wait");
    @(posedge clk_i);
    #1;
    if (!owner) m0_req_i = 1'b0;
    else        m1_req_i = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_done.size() == 0 && exp_issue.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (!ok) begin
      fail_note("drain_wait");
      exp_done.delete();
      exp_issue.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic xfer(input logic owner, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic err, input int lat, input int delay);
    mem_delay = delay;
    expect_xfer(owner, we, be, addr, wdata, rdata, err, lat);
    do_req(owner, we, be, addr, wdata);
    wait_drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {23'b0, m0_gnt_o, m1_gnt_o, m0_done_o, m1_done_o,
                           m0_err_o, m1_err_o, mem_req_o, mem_we_o, |mem_be_o}, 32'd0);
    check({tag, "_addr"},  mem_addr_o, 32'd0);
    check({tag, "_wdata"}, mem_wdata_o, 32'd0);
    check({tag, "_rdata"}, m0_rdata_o | m1_rdata_o, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h5A5A_5A5A;
    mem[2] = 32'h2222_2222;
    mem[3] = 32'h3333_3333;

    // Reset with both requesting: gnt must stay masked.
    rst_ni = 1'b0;
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_addr_i = 32'h8; m0_wdata_i = 32'h0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_addr_i = 32'hC; m1_wdata_i = 32'h0;
    #12;
    check_all_zero("reset_init");
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // m0 write then read: done rdata of the write is the old word.
    xfer(1'b0, 1'b1, 4'hF, 32'h4, 32'hABCD_EF90, 32'h5A5A_5A5A, 1'b0, 2, 0);
    xfer(1'b0, 1'b0, 4'hF, 32'h4, 32'h0,         32'hABCD_EF90, 1'b0, 2, 0);

    // m1 partial write: byte 0 keeps 0x90.
    xfer(1'b1, 1'b1, 4'hE, 32'h4, 32'h1234_5678, 32'hABCD_EF90, 1'b0, 2, 0);
    xfer(1'b1, 1'b0, 4'hF, 32'h4, 32'h0,         32'h1234_5690, 1'b0, 2, 0);

    // Round-robin: last owner is m1, so m0 wins the first tie.
    mem_delay = 0;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_xfer(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h2222_2222, 1'b0, 2);
      else            expect_xfer(1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 32'h3333_3333, 1'b0, 2);
    end
    gnt_log.delete();
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_addr_i = 32'h8; m0_wdata_i = 32'h0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_addr_i = 32'hC; m1_wdata_i = 32'h0;
    begin
      bit ok = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk_i);
        #1;
        if (gnt_log.size() >= 4) begin
          ok = 1;
          break;
        end
      end
      if (!ok) fail_note("rr_gnt_wait");
    end
    m0_req_i = 1'b0;
    m1_req_i = 1'b0;
    wait_drain();
    if (gnt_log.size() >= 4)
      for (int k = 1; k < 4; k++) check("rr_spacing", gnt_log[k] - gnt_log[k-1], 32'd3);

    // Timeout, then a normal read.
    xfer(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h0,         1'b1, 1 + TIMEOUT, NEVER);
    xfer(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h2222_2222, 1'b0, 2, 0);

    // Ready in the last RESP cycle beats the timeout.
    xfer(1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 32'h3333_3333, 1'b0, 1 + TIMEOUT, TIMEOUT - 1);

    // Reset mid-RESP on an m0 read: issue expected, no done.
    mem_delay = NEVER;
    exp_issue.push_back('{we: 1'b0, be: 4'hF, addr: 32'h8, wdata: 32'h0});
    do_req(1'b0, 1'b0, 4'hF, 32'h8, 32'h0);
    repeat (4) @(posedge clk_i);
    #2;
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_be_i = 4'hF; m0_addr_i = 32'h8; m0_wdata_i = 32'h0;
    m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m1_addr_i = 32'hC; m1_wdata_i = 32'h0;
    rst_ni = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk_i);
    #1;
    check_all_zero("reset_hold");

    // After release, the tie goes to m0 again.
    mem_delay = 0;
    expect_xfer(1'b0, 1'b0, 4'hF, 32'h8, 32'h0, 32'h2222_2222, 1'b0, 2);
    expect_xfer(1'b1, 1'b0, 4'hF, 32'hC, 32'h0, 32'h3333_3333, 1'b0, 2);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    fork
      do_req(1'b0, 1'b0, 4'hF, 32'h8, 32'h0);
      do_req(1'b1, 1'b0, 4'hF, 32'hC, 32'h0);
    join
    wait_drain();

    repeat (3) @(posedge clk_i);
    #1;
    check("queues_empty", exp_done.size() + exp_issue.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the external data memory (`ext_mem`). It shares the single memory port between the core load/store unit (m0) and a second master such as a DMA or debug unit (m1). It grants requesters round-robin, latches the granted request, and issues it to memory. It then waits for `ready` with a timeout and returns read data plus completion and error status to the owner.

## Interface
- `TIMEOUT`, default 16: maximum cycles spent in RESP waiting for `mem_ready_i` before aborting; must be ≥ 1.
- `clk_i` in, 1 bit: clock; all state updates on the rising edge.
- `rst_ni` in, 1 bit: asynchronous active-low reset.
- `m0_req_i` in, 1 bit: m0 request.
- `m0_we_i` in, 1 bit: m0 write enable.
- `m0_be_i` in, 4 bits: m0 byte enable.
- `m0_addr_i` in, 32 bits: m0 address.
- `m0_wdata_i` in, 32 bits: m0 write data.
- `m0_gnt_o` out, 1 bit: one-cycle pulse; m0 request accepted.
- `m0_done_o` out, 1 bit: one-cycle pulse; m0 transaction complete.
- `m0_err_o` out, 1 bit: valid with `m0_done_o`; set when the transaction timed out.
- `m0_rdata_o` out, 32 bits: read data; valid with `m0_done_o`.
- `m1_*`: identical set of ports for requester m1.
- `mem_req_o` out, 1 bit: memory request.
- `mem_we_o` out, 1 bit: memory write enable.
- `mem_be_o` out, 4 bits: memory byte enable.
- `mem_addr_o` out, 32 bits: memory address.
- `mem_wdata_o` out, 32 bits: memory write data.
- `mem_rdata_i` in, 32 bits: memory read data; valid in the cycle `mem_ready_i` = 1.
- `mem_ready_i` in, 1 bit: memory response ready.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- **IDLE:**
  - If any `mK_req_i` = 1, assert `mK_gnt_o` (combinational) for the selected owner.
  - At the clock edge, latch owner, `we`, `be`, `addr` and `wdata`, then go to ISSUE.
  - With no request, stay in IDLE.
- **Arbitration:**
  - A single requester wins.
  - If both request, the winner is the requester that is not `last_owner`.
  - `last_owner` updates on each grant and resets to 1, so m0 wins the first tie.
- **ISSUE:**
  - `mem_req_o` = 1 for exactly one cycle.
  - Clear the timeout counter and go to RESP.
- **RESP:**
  - `mem_req_o` = 0.
  - If `mem_ready_i` = 1: owner `done` = 1, `err` = 0, `rdata` = `mem_rdata_i` (pass-through, also for writes); go to IDLE.
  - Otherwise increment the counter.
  - If the counter equals TIMEOUT−1 and `mem_ready_i` = 0: owner `done` = 1, `err` = 1, `rdata` = 0; go to IDLE.
- `mem_we_o`, `mem_be_o`, `mem_addr_o` and `mem_wdata_o` always reflect the latched registers. They stay stable from ISSUE through RESP.
- The non-owner's `gnt`, `done`, `err` and `rdata` are always 0.
- **Requester rules:**
  - Hold `req` and the request fields stable until `gnt`.
  - Fields are don't-care after `gnt`.
  - A requester may re-request immediately. Arbitration happens only in IDLE.
- Byte enables are passed unmodified; partial-write merging is done by memory.
- The counter is $clog2(TIMEOUT+1) bits wide and never wraps; it is cleared on ISSUE.

## Timing
- **Reset** (asynchronous, any state):
  - State goes to IDLE, `last_owner` to 1, and the counter and latched fields to 0.
  - All outputs are 0 while `rst_ni` = 0.
  - Reset mid-transaction produces no `done` and no `mem_req_o`.
- **Latency:** grant in cycle 0 (IDLE), `mem_req_o` in cycle 1, `done` in cycle 2 at earliest (memory with ready in the first RESP cycle).
- **Throughput:** one transaction every 3 cycles. The next `gnt` comes no earlier than the cycle after `done`.
- **Timeout:** `done`/`err` arrive in the TIMEOUTth RESP cycle, i.e. cycle 1+TIMEOUT after the grant.
- A `req` arriving during ISSUE/RESP waits. A request that was pending during a transaction is arbitrated in the IDLE cycle following `done`.
- If `mem_ready_i` = 1 in the same cycle the timeout is reached, `ready` wins: `err` = 0.
- `mem_ready_i` is ignored outside RESP.

## Test plan
1. **Reset:**
   - Stimulus: assert `rst_ni` = 0 mid-RESP with `mem_ready_i` held 0.
   - Response: all outputs 0 immediately; no `done`; after release, first tie grants m0.
2. **Write/read m0:**
   - Stimulus: m0 writes addr 0x4, `be` 1111, data 0xABCDEF90, then reads addr 0x4.
   - Response: `gnt` cycle 0, `mem_req_o` cycle 1, `done` cycle 2; `m0_rdata_o` = 0xABCDEF90, `err` 0.
3. **Partial write m1:**
   - Stimulus: m1 writes addr 0x4, `be` 1110, data 0x12345678, then reads addr 0x4.
   - Response: `mem_be_o` = 1110 during ISSUE; read returns 0x12345690 on `m1_rdata_o`; m0 outputs stay 0.
4. **Round-robin:**
   - Stimulus: both request continuously for 4 transactions.
   - Response: grants m0, m1, m0, m1, each `gnt` in the IDLE cycle after the previous `done`; 3-cycle spacing.
5. **Timeout:**
   - Stimulus: memory model holds `ready` 0 with TIMEOUT=16.
   - Response: `done`+`err` = 1, `rdata` = 0, exactly 17 cycles after the grant.
   - Follow-up: a following normal read (ready restored) completes with `err` 0.
6. **Ready at limit:**
   - Stimulus: `mem_ready_i` rises in the 16th RESP cycle.
   - Response: `done` = 1, `err` = 0, `rdata` = `mem_rdata_i`.
